// File: rtl/dircc_types_pkg.sv
// Shared packet types for the DIRCC fabric.
//   address_t : hardware address word plus software address, port and flag
//               (the three low fields pack into 24 bits, MSB first).
//   packet_t  : destination, source, lamport clock and a 96-bit payload.
package dircc_types_pkg;

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t    dest_addr;
    address_t    src_addr;
    logic [31:0] lamport;
    logic [95:0] data;
  } packet_t;

endpackage

// File: rtl/dircc_avalon_st_packet_receiver.sv
// Avalon-ST sink that assembles fixed 8-beat packets into a packet_t.
//   clk, reset_n            : clock, asynchronous active-low reset
//   input_*                 : Avalon-ST sink (ready latency 0, ready registered)
//   packet_data/valid       : assembled packet, held until read_packet
//   read_packet             : consumer acknowledge (only meaningful while valid)
//   receiving               : a packet is partly received
//   packet_error            : one-cycle pulse when a malformed packet is dropped
module dircc_avalon_st_packet_receiver
  import dircc_types_pkg::*;
#(
  parameter int WORDS_PER_PACKET = 8,
  parameter int EMPTY_WIDTH      = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            input_data,
  input  logic                   input_valid,
  output logic                   input_ready,
  input  logic                   input_startofpacket,
  input  logic                   input_endofpacket,
  input  logic [EMPTY_WIDTH-1:0] input_empty,
  output packet_t                packet_data,
  output logic                   packet_valid,
  input  logic                   read_packet,
  output logic                   receiving,
  output logic                   packet_error
);

  typedef enum logic [1:0] {IDLE, RECV, FULL, DISCARD} state_t;

  state_t     state, state_n;
  logic [2:0] cnt, cnt_n;       // beats already stored in the current packet
  logic [2:0] store_idx;        // field slot for the beat being accepted
  logic       store, err_n;
  logic       accept, last, bad_frame;

  assign accept    = input_valid && input_ready;
  assign last      = (cnt == 3'(WORDS_PER_PACKET - 1));
  // eop or nonzero empty anywhere before the final beat is malformed
  assign bad_frame = input_endofpacket || (input_empty != '0);

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    err_n     = 1'b0;
    store     = 1'b0;
    store_idx = cnt;
    case (state)
      IDLE: if (accept) begin
        if (input_startofpacket && !bad_frame) begin
          store = 1'b1; store_idx = 3'd0; cnt_n = 3'd1; state_n = RECV;
        end else begin
          err_n = 1'b1;
          // a stray mid-packet beat means the rest of that packet follows
          if (!input_startofpacket && !input_endofpacket) state_n = DISCARD;
        end
      end
      RECV: if (accept) begin
        if (input_startofpacket) begin
          // abandon the partial packet; this beat may start a fresh one
          err_n = 1'b1;
          if (bad_frame) begin
            cnt_n = 3'd0; state_n = IDLE;
          end else begin
            store = 1'b1; store_idx = 3'd0; cnt_n = 3'd1;
          end
        end else if (!last) begin
          if (bad_frame) begin
            err_n = 1'b1; cnt_n = 3'd0; state_n = IDLE;
          end else begin
            store = 1'b1; cnt_n = cnt + 3'd1;
          end
        end else if (!input_endofpacket) begin
          err_n = 1'b1; cnt_n = 3'd0; state_n = DISCARD;
        end else if (input_empty != '0) begin
          err_n = 1'b1; cnt_n = 3'd0; state_n = IDLE;
        end else begin
          store = 1'b1; cnt_n = 3'd0; state_n = FULL;
        end
      end
      FULL:    if (read_packet) state_n = IDLE;
      DISCARD: if (accept && input_endofpacket) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= 3'd0;
      input_ready  <= 1'b0;
      packet_valid <= 1'b0;
      receiving    <= 1'b0;
      packet_error <= 1'b0;
      packet_data  <= '0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      input_ready  <= (state_n != FULL);
      packet_valid <= (state_n == FULL);
      // stays up through the cycle after the final beat is taken
      receiving    <= (state_n == RECV) || (state == RECV && state_n == FULL);
      packet_error <= err_n;
      if (store) begin
        case (store_idx)
          3'd0: packet_data.dest_addr.hw_addr <= input_data;
          3'd1: {packet_data.dest_addr.sw_addr, packet_data.dest_addr.port,
                 packet_data.dest_addr.flag} <= input_data[31:8];
          3'd2: packet_data.src_addr.hw_addr <= input_data;
          3'd3: {packet_data.src_addr.sw_addr, packet_data.src_addr.port,
                 packet_data.src_addr.flag} <= input_data[31:8];
          3'd4: packet_data.lamport <= input_data;
          3'd5: packet_data.data[31:0] <= input_data;
          3'd6: packet_data.data[63:32] <= input_data;
          3'd7: packet_data.data[95:64] <= input_data;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dircc_avalon_st_packet_receiver.sv
// Self-checking bench for dircc_avalon_st_packet_receiver: a scoreboard of
// expected packets compared when packet_valid rises, a table of malformed
// framing cases, and hand-written reset/backpressure/restart sequences.
module tb_dircc_avalon_st_packet_receiver;
  import dircc_types_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] input_data;
  logic        input_valid, input_ready;
  logic        input_startofpacket, input_endofpacket;
  logic [1:0]  input_empty;
  packet_t     packet_data;
  logic        packet_valid, read_packet, receiving, packet_error;

  always #5 clk = ~clk;

  dircc_avalon_st_packet_receiver #(.WORDS_PER_PACKET(8), .EMPTY_WIDTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
    .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
    .input_startofpacket(input_startofpacket), .input_endofpacket(input_endofpacket),
    .input_empty(input_empty),
    .packet_data(packet_data), .packet_valid(packet_valid), .read_packet(read_packet),
    .receiving(receiving), .packet_error(packet_error)
  );

  int n_checks = 0, n_pass = 0;
  int n_err = 0, n_rx = 0, n_recv = 0;
  bit pv_q = 1'b0, auto_read = 1'b1;
  packet_t exp_q[$];

  logic [31:0] bd[8];
  logic        bs[8], be[8];
  logic [1:0]  bm[8];

  typedef struct {
    int kind;     // 0 none, 1 clear sop, 2 set eop, 3 set empty, 4 clear eop, 5 set sop
    int m;        // beat index modified (0-based)
    int len;      // beats sent
    bit tail;     // follow with a lone eop beat
    int exp_err;  // expected error pulses
    int exp_pkt;  // expected delivered packets
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // Scoreboard / event monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (reset_n) begin
      if (packet_error) n_err++;
      if (receiving) n_recv++;
      if (packet_valid && !pv_q) begin
        n_rx++;
        if (exp_q.size() == 0) check("unexpected_pkt", 256'(packet_data), 256'd0);
        else check("pkt_data", 256'(packet_data), 256'(exp_q.pop_front()));
      end
    end
    pv_q = packet_valid;
  end

  // Auto consumer: acknowledge as soon as a packet is presented.
  always @(negedge clk) if (auto_read) read_packet = packet_valid;

  function automatic packet_t rand_pkt();
    packet_t p;
    p.dest_addr.hw_addr = $urandom;
    p.dest_addr.sw_addr = 16'($urandom);
    p.dest_addr.port    = 7'($urandom);
    p.dest_addr.flag    = 1'($urandom);
    p.src_addr.hw_addr  = $urandom;
    p.src_addr.sw_addr  = 16'($urandom);
    p.src_addr.port     = 7'($urandom);
    p.src_addr.flag     = 1'($urandom);
    p.lamport           = $urandom;
    p.data              = {$urandom, $urandom, $urandom};
    return p;
  endfunction

  // Fill the beat buffer with a well-formed packet; low bytes of b2/b4 are junk.
  task automatic build_good(input packet_t p);
    bd[0] = p.dest_addr.hw_addr;
    bd[1] = {p.dest_addr.sw_addr, p.dest_addr.port, p.dest_addr.flag, 8'($urandom)};
    bd[2] = p.src_addr.hw_addr;
    bd[3] = {p.src_addr.sw_addr, p.src_addr.port, p.src_addr.flag, 8'($urandom)};
    bd[4] = p.lamport;
    bd[5] = p.data[31:0];
    bd[6] = p.data[63:32];
    bd[7] = p.data[95:64];
    for (int i = 0; i < 8; i++) begin
      bs[i] = (i == 0); be[i] = (i == 7); bm[i] = 2'd0;
    end
  endtask

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic drive_beat(input logic [31:0] d, input logic s, input logic e,
                            input logic [1:0] em, input bit gaps);
    int t, g;
    g = (gaps && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 2)) : 0;
    repeat (g) @(negedge clk);
    input_data = d; input_startofpacket = s; input_endofpacket = e;
    input_empty = em; input_valid = 1'b1;
    t = 0;
    while (!input_ready && t < 100) begin @(negedge clk); t++; end
    if (!input_ready) check("ready_timeout", 256'd0, 256'd1);
    @(negedge clk);
    input_valid = 1'b0; input_startofpacket = 1'b0;
    input_endofpacket = 1'b0; input_empty = 2'd0;
  endtask

  task automatic send_cur(input int len, input bit gaps);
    for (int i = 0; i < len; i++) drive_beat(bd[i], bs[i], be[i], bm[i], gaps);
  endtask

  task automatic send_good(input bit gaps);
    packet_t p;
    p = rand_pkt();
    build_good(p);
    exp_q.push_back(p);
    send_cur(8, gaps);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 256'(input_ready), 256'd0);
    check({tag, "_valid"}, 256'(packet_valid), 256'd0);
    check({tag, "_recv"}, 256'(receiving), 256'd0);
    check({tag, "_err"}, 256'(packet_error), 256'd0);
    check({tag, "_data"}, 256'(packet_data), 256'd0);
  endtask

  initial begin
    int e0, r0, v0, bad_rdy, bad_stab;
    packet_t held, p;

    vecs[0] = '{0, 0, 8, 1'b0, 0, 1};
    vecs[1] = '{2, 4, 5, 1'b0, 1, 0};
    vecs[2] = '{3, 2, 8, 1'b0, 2, 0};
    vecs[3] = '{1, 0, 8, 1'b0, 1, 0};
    vecs[4] = '{4, 7, 8, 1'b1, 1, 0};
    vecs[5] = '{3, 7, 8, 1'b0, 1, 0};
    vecs[6] = '{5, 5, 8, 1'b0, 2, 0};

    input_data = '0; input_valid = 1'b0; input_startofpacket = 1'b0;
    input_endofpacket = 1'b0; input_empty = 2'd0; read_packet = 1'b0;
    reset_n = 1'b0;

    // Reset: 10 clocks low, outputs quiet, ready on the first edge after release.
    repeat (10) @(negedge clk);
    check_reset_outputs("rst");
    reset_n = 1'b1;
    #1 check("ready_before_edge", 256'(input_ready), 256'd0);
    @(negedge clk);
    check("ready_after_release", 256'(input_ready), 256'd1);

    // Single full-rate packet: latency, content (scoreboard), receiving width.
    e0 = n_err; v0 = n_recv;
    send_good(1'b0);
    check("latency_valid", 256'(packet_valid), 256'd1);
    repeat (4) @(negedge clk);
    check("single_recv_cycles", 256'(n_recv - v0), 256'd8);
    check("single_no_err", 256'(n_err - e0), 256'd0);

    // Backpressure: hold read_packet low for 20 cycles.
    auto_read = 1'b0; read_packet = 1'b0;
    send_good(1'b0);
    held = packet_data; bad_rdy = 0; bad_stab = 0;
    repeat (20) begin
      @(negedge clk);
      if (input_ready !== 1'b0) bad_rdy++;
      if (packet_data !== held || packet_valid !== 1'b1) bad_stab++;
    end
    check("bp_ready_low", 256'(bad_rdy), 256'd0);
    check("bp_data_stable", 256'(bad_stab), 256'd0);
    read_packet = 1'b1;
    @(negedge clk);
    read_packet = 1'b0;
    check("bp_valid_cleared", 256'(packet_valid), 256'd0);
    check("bp_ready_back", 256'(input_ready), 256'd1);
    auto_read = 1'b1;
    r0 = n_rx;
    send_good(1'b0);
    repeat (3) @(negedge clk);
    check("bp_second_pkt", 256'(n_rx - r0), 256'd1);

    // Table of framing faults, each followed by a recovery packet.
    foreach (vecs[k]) begin
      p = rand_pkt();
      build_good(p);
      case (vecs[k].kind)
        1: bs[vecs[k].m] = 1'b0;
        2: be[vecs[k].m] = 1'b1;
        3: bm[vecs[k].m] = 2'($urandom_range(1, 3));
        4: be[vecs[k].m] = 1'b0;
        5: bs[vecs[k].m] = 1'b1;
        default: ;
      endcase
      if (vecs[k].exp_pkt != 0) exp_q.push_back(p);
      e0 = n_err; r0 = n_rx;
      send_cur(vecs[k].len, 1'b0);
      if (vecs[k].tail) drive_beat($urandom, 1'b0, 1'b1, 2'd0, 1'b0);
      repeat (4) @(negedge clk);
      check($sformatf("vec%0d_err", k), 256'(n_err - e0), 256'(vecs[k].exp_err));
      check($sformatf("vec%0d_pkt", k), 256'(n_rx - r0), 256'(vecs[k].exp_pkt));
      e0 = n_err; r0 = n_rx;
      send_good(1'b0);
      repeat (3) @(negedge clk);
      check($sformatf("vec%0d_recover", k), 256'(n_rx - r0 + 10 * (n_err - e0)), 256'd1);
    end

    // sop on b4: partial packet dropped, new packet starting there kept.
    e0 = n_err; r0 = n_rx;
    build_good(rand_pkt());
    send_cur(3, 1'b0);
    send_good(1'b0);
    repeat (3) @(negedge clk);
    check("restart_err", 256'(n_err - e0), 256'd1);
    check("restart_pkt", 256'(n_rx - r0), 256'd1);

    // Back-to-back full-rate packets.
    e0 = n_err; r0 = n_rx;
    send_good(1'b0);
    send_good(1'b0);
    repeat (3) @(negedge clk);
    check("b2b_pkts", 256'(n_rx - r0), 256'd2);
    check("b2b_err", 256'(n_err - e0), 256'd0);

    // Random valid gaps across 3 packets.
    e0 = n_err; r0 = n_rx;
    for (int i = 0; i < 3; i++) send_good(1'b1);
    repeat (3) @(negedge clk);
    check("gap_pkts", 256'(n_rx - r0), 256'd3);
    check("gap_err", 256'(n_err - e0), 256'd0);

    // Reset while b3 of a 4th packet is on the bus.
    build_good(rand_pkt());
    send_cur(2, 1'b1);
    input_data = bd[2]; input_valid = 1'b1;
    reset_n = 1'b0;
    #1 check_reset_outputs("midrst");
    repeat (3) @(negedge clk);
    input_valid = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    e0 = n_err; r0 = n_rx;
    send_good(1'b0);
    repeat (3) @(negedge clk);
    check("midrst_pkt", 256'(n_rx - r0), 256'd1);
    check("midrst_err", 256'(n_err - e0), 256'd0);

    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/dircc_avalon_st_packet_receiver.md
DIRCC_AVALON_ST_PACKET_RECEIVER -- requirements
Module: dircc_avalon_st_packet_receiver

Interface
Parameters:
REQ-001 SHALL have parameter WORDS_PER_PACKET, default 8, meaning beats per packet; only 8 is supported.
REQ-002 SHALL have parameter EMPTY_WIDTH, default 2, meaning the width of the input_empty port.
Ports (name, direction, width, meaning):
REQ-003 SHALL have clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have input_data, input, 32, Avalon-ST sink data.
REQ-006 SHALL have input_valid, input, 1, Avalon-ST sink valid.
REQ-007 SHALL have input_ready, output, 1, Avalon-ST sink ready; ready latency 0; registered.
REQ-008 SHALL have input_startofpacket and input_endofpacket, input, 1 each, Avalon-ST framing.
REQ-009 SHALL have input_empty, input, EMPTY_WIDTH, Avalon-ST empty; sampled only for the error check.
REQ-010 SHALL have packet_data, output, packet_t (dircc_types_pkg), the assembled packet.
REQ-011 SHALL have packet_valid, output, 1, high while packet_data holds an unread packet.
REQ-012 SHALL have read_packet, input, 1, consumer acknowledge of packet_data.
REQ-013 SHALL have receiving, output, 1, high while a packet is partly received.
REQ-014 SHALL have packet_error, output, 1, one-cycle pulse when a malformed packet is dropped.

Function
REQ-015 A beat SHALL be accepted only on a rising edge where input_valid and input_ready are both 1.
REQ-016 Beat-to-field mapping SHALL be:
- b1 = dest_addr.hw_addr
- b2[31:8] = {dest_addr.sw_addr, dest_addr.port, dest_addr.flag}, MSB first; b2[7:0] ignored
- b3 = src_addr.hw_addr
- b4[31:8] = {src_addr.sw_addr, src_addr.port, src_addr.flag}, MSB first; b4[7:0] ignored
- b5 = lamport
- b6 = data[31:0]; b7 = data[63:32]; b8 = data[95:64]
REQ-017 A well-formed packet SHALL have:
- sop=1 on b1 only
- eop=1 on b8 only
- empty=0 on every beat
REQ-018 The state machine SHALL have the states IDLE, RECV, FULL and DISCARD, plus a 3-bit beat counter.
REQ-019 IDLE SHALL behave as follows:
- input_ready=1
- on an accepted beat with sop=1: store b1, set counter=1, go to RECV
- on an accepted beat with sop=0: drop it, pulse packet_error, go to DISCARD (or stay in IDLE if eop=1)
REQ-020 RECV SHALL behave as follows:
- input_ready=1
- each accepted beat is stored in the field given by the counter, then the counter increments
REQ-021 In RECV, an accepted beat with sop=1 SHALL discard the partial packet, pulse packet_error, and restart as b1 with counter=1.
REQ-022 In RECV, an accepted beat with eop=1 or empty!=0 before b8 SHALL pulse packet_error and return to IDLE, dropping the partial packet.
REQ-023 In RECV, an accepted b8 with eop=0 SHALL pulse packet_error and go to DISCARD.
REQ-024 In RECV, an accepted well-formed b8 SHALL go to FULL, with packet_valid=1 and the updated packet_data on the next cycle.
REQ-025 In DISCARD, input_ready SHALL be 1, accepted beats SHALL be dropped, and the block SHALL go to IDLE after accepting a beat with eop=1.
REQ-026 In FULL:
- input_ready=0
- packet_data and packet_valid are held stable
- read_packet=1 clears packet_valid, sets input_ready=1, and moves to IDLE on the next cycle
REQ-027 read_packet SHALL be ignored when packet_valid=0.
REQ-028 receiving SHALL equal 1 exactly in the RECV state, from the cycle after b1 is accepted to the cycle after b8 is accepted.
REQ-029 Latency SHALL be one clock from acceptance of b8 to packet_valid=1.
REQ-030 At full input rate, the block SHALL accept back-to-back 8-beat packets with one idle cycle for the read_packet handshake plus one FULL cycle, and lose no beats.
REQ-031 Deasserting input_valid mid-packet SHALL stall the packet without error and without a timeout.
REQ-032 packet_error SHALL be a single-cycle pulse per detected error; only one pulse is generated per cycle.

Reset
REQ-033 While reset_n=0, regardless of clk, the block SHALL:
- set state=IDLE and counter=0
- set input_ready=0, packet_valid=0, receiving=0, packet_error=0
- clear packet_data to all zeros
REQ-034 input_ready SHALL rise on the first rising edge after reset_n deasserts.
REQ-035 Reset asserted mid-packet or in FULL SHALL discard all state, and the first post-reset packet SHALL be received correctly.

Verification
REQ-036 Reset check: assert reset_n=0 for 10 clocks -> all outputs 0; first edge after release -> input_ready=1.
REQ-037 Single packet: 8 beats with random fields, sop on b1, eop on b8, empty=0 -> packet_valid=1 one clock after b8; every packet_t field matches, b2/b4[7:0] ignored; receiving high for exactly 8 cycles at full rate.
REQ-038 Backpressure: hold read_packet=0 for 20 cycles after the packet completes -> input_ready=0 and packet_data stable throughout; read_packet=1 -> packet_valid=0 and input_ready=1 on the next cycle; a second packet is then received intact.
REQ-039 Early eop on b5 -> packet_error pulses once, packet_valid stays 0, state returns to IDLE; a following good packet is received correctly.
REQ-040 sop on b4 mid-packet -> one error pulse, and the new 8-beat packet starting at that beat is received correctly.
REQ-041 Random input_valid gaps (about 50% duty) across 3 packets -> 3 correct packets and no packet_error; assert reset_n=0 at b3 of a 4th packet -> clean recovery.
